mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer between the main decoder's memory-control outputs and the external data-memory bus. It accepts a load/store request (memReq, memWrite, funct3) plus the effective address and store data from the execute stage. It then runs a req/ack bus transaction with correct byte enables and replicated store data, and stalls the core until the access completes. Returned load data is aligned and sign/zero-extended per funct3 before going to the writeback mux.

## Interface
Parameters:
- TIMEOUT_CYC, 255: max BUSY cycles without ack before abort; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- i_memReq  in  1  decoder memory request
- i_memWrite  in  1  1 = store, 0 = load
- i_funct3  in  3  access width/sign (RV32I load/store encoding)
- i_addr  in  32  effective byte address
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  hold PC/pipeline
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load data
- o_fault  out  1  misaligned or illegal funct3; access not issued
- o_timeout  out  1  one-cycle pulse on bus timeout
- o_bus_req  out  1  bus request
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  32  word address: {addr[31:2],2'b00}
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ack  in  1  bus completion, valid only while o_bus_req=1
- i_bus_rdata  in  32  read word, valid with i_bus_ack

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: when i_memReq=1 and access is legal, latch addr/funct3/we/be/wdata and go to BUSY. When the access is illegal, o_fault=1 (combinational), no latch, stay IDLE, o_stall=0.
- Legality:
  - funct3 000/100 (byte): any address.
  - 001/101 (half): addr[0]=0.
  - 010 (word): addr[1:0]=0.
  - Loads with 011/110/111, or stores with funct3[2]=1 or 011: illegal.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
  - Loads drive the same be.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- BUSY: o_bus_req=1, o_bus_we/addr/be/wdata held stable from latched values. On i_bus_ack, capture i_bus_rdata into rdata register and go to DONE.
- DONE:
  - o_done=1, o_stall=0, unconditional return to IDLE.
  - i_memReq in DONE belongs to the completed instruction and is ignored.
- Load extension from latched offset:
  - LB/LBU: selected byte, sign/zero-extended.
  - LH/LHU: selected half, sign/zero-extended.
  - LW: full word.
- o_rdata holds the last completed load value until the next load completes. Stores do not change it.
- o_stall = (IDLE & i_memReq & legal) | BUSY.
- i_bus_ack outside BUSY is ignored.

## Timing
- Reset (rst_n=0 at edge): state IDLE, rdata register 0, timeout counter 0.
- Values during and after reset: o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_done=0, o_timeout=0, o_stall=0. o_fault follows inputs combinationally.
- Reset mid-BUSY: o_bus_req drops at that edge and no o_done is produced.
- Latency: request accepted in cycle T; o_bus_req from T+1. Ack in cycle T+k (k≥1) gives o_done at T+k+1. Minimum is 2 cycles to o_done.
- Throughput: one access per 3 cycles minimum (IDLE→BUSY→DONE).

## Configuration
- MEM_TIMEOUT_EN defined:
  - 8+ bit counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYC, drop o_bus_req and enter DONE with o_timeout=1 and o_done=1.
  - For a load, o_rdata = 0.
  - Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter, BUSY waits indefinitely, o_timeout tied 0, TIMEOUT_CYC unused.

## Test plan
- LW, funct3=010, addr 0x0000_1004, ack 3 cycles after req with rdata 0xDEAD_BEEF -> bus_addr 0x1004, be 1111. o_stall high 4 cycles, then o_done with o_rdata 0xDEAD_BEEF.
- LB, addr 0x0000_2003, rdata 0x80FF_FF00 -> be 1000, o_rdata 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH, addr 0x0000_3002, wdata 0x1234_ABCD -> bus_we=1, be 1100, bus_wdata 0xABCD_ABCD. o_rdata unchanged.
- LW at addr 0x0000_4002 -> o_fault=1 same cycle, o_bus_req never asserts, o_stall=0. funct3=011 load -> o_fault=1.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=4, no ack -> req held 4 cycles, then o_timeout=o_done=1, o_rdata=0.
- rst_n=0 during BUSY -> next cycle o_bus_req=0, o_stall=0, no o_done. A late ack afterwards is ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: req/ack transaction, byte lanes, load extension.
// Optional MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYC cycles.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_timeout,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        legal;
    logic        accept;
    logic        expire;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] lane;
    logic [31:0] load_ext;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            (i_funct3[1:0] == 2'b00):
                legal = !(i_memWrite && i_funct3[2]);
            (i_funct3[1:0] == 2'b01):
                legal = !i_addr[0] && !(i_memWrite && i_funct3[2]);
            (i_funct3 == 3'b010):
                legal = (i_addr[1:0] == 2'b00);
            default:
                legal = 1'b0;
        endcase
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = i_wdata;
        unique case (i_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << i_addr[1:0];
                wdata_rep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {i_addr[1], 1'b0};
                wdata_rep = {2{i_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = i_wdata;
            end
        endcase
    end

    // Reset also masks the stall so the core is never held while in reset.
    assign accept = rst_n && (state_q == IDLE) && i_memReq && legal;

    always_comb begin
        lane     = i_bus_rdata >> {addr_q[1:0], 3'b000};
        load_ext = lane;
        unique case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                        $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic          to_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= expire;
            if (accept)
                cnt_q <= '0;
            else if (state_q == BUSY && !i_bus_ack)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // An ack arriving in the expiry cycle completes normally.
    assign expire = (state_q == BUSY) && !i_bus_ack &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign o_timeout = (state_q == DONE) && to_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (i_bus_ack || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= i_memWrite;
                f3_q    <= i_funct3;
                addr_q  <= i_addr;
                be_q    <= be;
                wdata_q <= wdata_rep;
            end
            if (state_q == BUSY && i_bus_ack && !we_q)
                rdata_q <= load_ext;
            else if (expire && !we_q)
                rdata_q <= '0;
        end
    end

    always_comb begin
        o_bus_req   = (state_q == BUSY);
        o_bus_we    = o_bus_req && we_q;
        o_bus_addr  = o_bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        o_bus_be    = o_bus_req ? be_q : 4'h0;
        o_bus_wdata = o_bus_req ? wdata_q : 32'h0;
        o_stall     = accept || o_bus_req;
        o_done      = (state_q == DONE);
        o_fault     = (state_q == IDLE) && i_memReq && !legal;
        o_rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl.
// Define MEM_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYC=4).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_memReq;
    logic        i_memWrite;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_timeout;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_memReq(i_memReq), .i_memWrite(i_memWrite),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
        .o_fault(o_fault), .o_timeout(o_timeout),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
    );

    // Reference model: access size in bytes drives everything.
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] f3,
                                   input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        return (off % m_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [31:0] a);
        int v;
        v = ((1 << m_bytes(f3)) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] w);
        if (m_bytes(f3) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (m_bytes(f3) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] mask;
        logic [31:0] v;
        int nb;
        nb   = m_bytes(f3);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
        v    = (rd >> (8 * int'(a[1:0]))) & mask;
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // One full access; k is the BUSY cycle carrying the ack.
    task automatic access(input logic [2:0] f3, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int k, input logic [31:0] rd);
        bit lg;
        lg = m_legal(we, f3, a);
        @(posedge clk); #1;
        i_memReq = 1'b1; i_memWrite = we; i_funct3 = f3;
        i_addr = a; i_wdata = wd; i_bus_ack = 1'b0;
        #3;
        checks++;
        if ({o_fault, o_stall, o_bus_req, o_done} !== {!lg, lg, 2'b00}) begin
            errors++;
            $display("FAIL issue: fault/stall/req/done=%b want %b",
                     {o_fault, o_stall, o_bus_req, o_done}, {!lg, lg, 2'b00});
        end
        if (!lg) begin
            @(posedge clk); #1;
            i_memReq = 1'b0;
            #3;
            checks++;
            if ({o_bus_req, o_stall, o_done} !== 3'b000 || o_rdata !== last_rd) begin
                errors++;
                $display("FAIL fault_idle: req/stall/done=%b rdata=%h want 000 %h",
                         {o_bus_req, o_stall, o_done}, o_rdata, last_rd);
            end
            return;
        end
        for (int j = 1; j <= k; j++) begin
            @(posedge clk); #1;
            i_bus_ack   = (j == k);
            i_bus_rdata = (j == k) ? rd : $urandom;
            i_addr      = $urandom;
            i_wdata     = $urandom;
            #3;
            checks++;
            if ({o_bus_req, o_bus_we, o_bus_be, o_stall, o_done} !==
                {1'b1, we, m_be(f3, a), 1'b1, 1'b0} ||
                o_bus_addr !== {a[31:2], 2'b00} ||
                o_bus_wdata !== m_wdata(f3, wd)) begin
                errors++;
                $display("FAIL busy: req/we/be/stall/done=%b addr=%h wdata=%h want %b %h %h",
                         {o_bus_req, o_bus_we, o_bus_be, o_stall, o_done},
                         o_bus_addr, o_bus_wdata,
                         {1'b1, we, m_be(f3, a), 1'b1, 1'b0},
                         {a[31:2], 2'b00}, m_wdata(f3, wd));
            end
        end
        @(posedge clk); #1;
        i_bus_ack   = 1'b0;
        i_bus_rdata = $urandom;
        #3;
        if (!we) last_rd = m_load(f3, a, rd);
        checks++;
        if ({o_done, o_stall, o_bus_req, o_timeout} !== 4'b1000 ||
            o_rdata !== last_rd) begin
            errors++;
            $display("FAIL done: done/stall/req/timeout=%b rdata=%h want 1000 %h",
                     {o_done, o_stall, o_bus_req, o_timeout}, o_rdata, last_rd);
        end
    endtask

    // Idle cycle with a stray ack that must be ignored.
    task automatic idle_cycle();
        @(posedge clk); #1;
        i_memReq = 1'b0; i_bus_ack = 1'b1; i_bus_rdata = $urandom;
        #3;
        @(posedge clk); #1;
        i_bus_ack = 1'b0;
        #3;
        checks++;
        if ({o_bus_req, o_stall, o_done} !== 3'b000 || o_rdata !== last_rd) begin
            errors++;
            $display("FAIL idle: req/stall/done=%b rdata=%h want 000 %h",
                     {o_bus_req, o_stall, o_done}, o_rdata, last_rd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_memReq = 1'b1; i_memWrite = 1'b0;
        i_funct3 = 3'b010; i_addr = 32'h1000; i_wdata = $urandom;
        i_bus_ack = 1'b1; i_bus_rdata = $urandom;
        repeat (3) @(posedge clk);
        #4;
        checks++;
        if ({o_bus_req, o_bus_we, o_bus_be, o_done, o_timeout, o_stall, o_fault} !== 9'b0 ||
            o_bus_addr !== 32'h0 || o_bus_wdata !== 32'h0 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: flags=%b addr=%h wdata=%h rdata=%h want all 0",
                     {o_bus_req, o_bus_we, o_bus_be, o_done, o_timeout, o_stall, o_fault},
                     o_bus_addr, o_bus_wdata, o_rdata);
        end
        i_funct3 = 3'b011;
        #1;
        checks++;
        if (o_fault !== 1'b1) begin
            errors++;
            $display("FAIL reset_fault: fault=%b want 1", o_fault);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; i_memReq = 1'b0; i_bus_ack = 1'b0;
    endtask

    task automatic test_directed();
        access(3'b010, 1'b0, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF);
        checks++;
        if (o_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw: rdata=%h want deadbeef", o_rdata);
        end
        access(3'b000, 1'b0, 32'h0000_2003, 32'h0, 1, 32'h80FF_FF00);
        checks++;
        if (o_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb: rdata=%h want ffffff80", o_rdata);
        end
        access(3'b100, 1'b0, 32'h0000_2003, 32'h0, 2, 32'h80FF_FF00);
        checks++;
        if (o_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: rdata=%h want 00000080", o_rdata);
        end
        access(3'b001, 1'b1, 32'h0000_3002, 32'h1234_ABCD, 2, 32'h5555_5555);
        checks++;
        if (o_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL sh_rdata: rdata=%h want 00000080", o_rdata);
        end
        idle_cycle();
        access(3'b010, 1'b0, 32'h0000_4002, 32'h0, 1, 32'h0);
        access(3'b011, 1'b0, 32'h0000_4000, 32'h0, 1, 32'h0);
        access(3'b100, 1'b1, 32'h0000_4000, 32'h0, 1, 32'h0);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        access(3'b010, 1'b0, 32'h0000_5000, 32'h0, 1, 32'h1357_9BDF);
        @(posedge clk); #1;
        i_memReq = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h0000_6000; i_bus_ack = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #4;
            checks++;
            if ({o_bus_req, o_done, o_timeout} !== 3'b100) begin
                errors++;
                $display("FAIL to_busy%0d: req/done/timeout=%b want 100", j,
                         {o_bus_req, o_done, o_timeout});
            end
        end
        @(posedge clk); #4;
        last_rd = 32'h0;
        checks++;
        if ({o_bus_req, o_done, o_timeout} !== 3'b011 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout: req/done/timeout=%b rdata=%h want 011 0",
                     {o_bus_req, o_done, o_timeout}, o_rdata);
        end
        access(3'b010, 1'b0, 32'h0000_7000, 32'h0, 4, 32'hCAFE_F00D);
    endtask
`else
    task automatic test_timeout();
        access(3'b010, 1'b0, 32'h0000_5000, 32'h0, 20, 32'h1357_9BDF);
    endtask
`endif

    task automatic test_reset_busy();
        @(posedge clk); #1;
        i_memReq = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h0000_8000; i_bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        checks++;
        if (o_bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: req=%b want 1", o_bus_req);
        end
        @(posedge clk); #1;
        i_memReq = 1'b0;
        #3;
        last_rd = 32'h0;
        checks++;
        if ({o_bus_req, o_stall, o_done} !== 3'b000 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy: req/stall/done=%b rdata=%h want 000 0",
                     {o_bus_req, o_stall, o_done}, o_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        i_bus_ack = 1'b0;
        #3;
        checks++;
        if ({o_bus_req, o_done} !== 2'b00 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL late_ack: req/done=%b rdata=%h want 00 0",
                     {o_bus_req, o_done}, o_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            access(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom_range(1, 4), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    initial begin
        i_bus_rdata = 32'h0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_busy();
        test_random();
        idle_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
